// File: rtl/prf_freelist.sv
// Physical-register free list: dual-slot rename allocation, dual-slot commit release,
// and single-cycle flush recovery to the committed head.
module prf_freelist #(
  parameter int unsigned PRF_NUM       = 64,
  parameter int unsigned ARCH_NUM      = 34,
  parameter int unsigned FL_DEPTH      = 32,
  parameter int unsigned PRF_NUM_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   alloc_req,
  output logic                         alloc_ok,
  output logic [PRF_NUM_WIDTH-1:0]     alloc_preg_0,
  output logic [PRF_NUM_WIDTH-1:0]     alloc_preg_1,
  input  logic [1:0]                   commit_alloc,
  input  logic [1:0]                   commit_free_valid,
  input  logic [PRF_NUM_WIDTH-1:0]     commit_free_preg_0,
  input  logic [PRF_NUM_WIDTH-1:0]     commit_free_preg_1,
  input  logic                         flush,
  output logic [$clog2(FL_DEPTH):0]    free_count
);

  localparam int unsigned IDX_W     = $clog2(FL_DEPTH);
  localparam int unsigned PTR_W     = IDX_W + 1;
  localparam int unsigned INIT_FREE = PRF_NUM - ARCH_NUM;

  logic [PRF_NUM_WIDTH-1:0] fl [FL_DEPTH];
  logic [PTR_W-1:0]         head, chead, tail;
  logic [PTR_W-1:0]         head_nxt, chead_nxt, tail_nxt;
  logic [1:0]               nreq, ncommit, nfree;
  logic [IDX_W-1:0]         hidx, hidx1, tidx, tidx1;

  // Grant lookup and next-pointer computation, all from registered state.
  always_comb begin
    nreq       = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
    ncommit    = {1'b0, commit_alloc[0]} + {1'b0, commit_alloc[1]};
    nfree      = {1'b0, commit_free_valid[0]} + {1'b0, commit_free_valid[1]};
    free_count = tail - head;
    alloc_ok   = (free_count >= PTR_W'(nreq));
    hidx       = head[IDX_W-1:0];
    hidx1      = IDX_W'(hidx + IDX_W'(1));
    tidx       = tail[IDX_W-1:0];
    tidx1      = IDX_W'(tidx + IDX_W'(1));
    alloc_preg_0 = fl[hidx];
    alloc_preg_1 = alloc_req[0] ? fl[hidx1] : fl[hidx];
    chead_nxt  = chead + PTR_W'(ncommit);
    tail_nxt   = tail + PTR_W'(nfree);
    head_nxt   = head;
    if (flush) begin
      head_nxt = chead_nxt;
    end else if (alloc_ok) begin
      head_nxt = head + PTR_W'(nreq);
    end
  end

  // Pointer and queue storage update; slot 0 is pushed ahead of slot 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      chead <= '0;
      tail  <= PTR_W'(INIT_FREE);
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        fl[i] <= (i < INIT_FREE) ? PRF_NUM_WIDTH'(ARCH_NUM + i) : '0;
      end
    end else begin
      head  <= head_nxt;
      chead <= chead_nxt;
      tail  <= tail_nxt;
      if (commit_free_valid[0]) begin
        fl[tidx] <= commit_free_preg_0;
      end
      if (commit_free_valid[1]) begin
        fl[commit_free_valid[0] ? tidx1 : tidx] <= commit_free_preg_1;
      end
    end
  end

  // Releases must never overfill the queue relative to the committed head.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    PTR_W'(tail_nxt - chead_nxt) <= PTR_W'(FL_DEPTH));

  // Commit may only retire registers that were actually allocated.
  a_chead_le_head: assert property (@(posedge clk) disable iff (!rst_n)
    PTR_W'(ncommit) <= PTR_W'(head - chead));

endmodule

// File: tb/tb_prf_freelist.sv
// Scoreboarded bench for prf_freelist: directed recovery scenarios followed by
// constrained-random traffic checked against a reference queue model.
module tb_prf_freelist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] alloc_req;
  logic       alloc_ok;
  logic [5:0] alloc_preg_0, alloc_preg_1;
  logic [1:0] commit_alloc, commit_free_valid;
  logic [5:0] commit_free_preg_0, commit_free_preg_1;
  logic       flush;
  logic [5:0] free_count;

  prf_freelist dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_ok(alloc_ok),
    .alloc_preg_0(alloc_preg_0), .alloc_preg_1(alloc_preg_1),
    .commit_alloc(commit_alloc), .commit_free_valid(commit_free_valid),
    .commit_free_preg_0(commit_free_preg_0), .commit_free_preg_1(commit_free_preg_1),
    .flush(flush), .free_count(free_count)
  );

  always #5 clk = ~clk;

  // mask bits: 0 free_count, 1 alloc_ok, 2 alloc_preg_0, 3 alloc_preg_1
  typedef struct {
    logic [5:0] fc;
    logic       ok;
    logic [5:0] p0;
    logic [5:0] p1;
    logic [3:0] m;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;
  exp_t  e;
  string nm;

  // Reference queue model.
  logic [5:0] mfl [32];
  logic [5:0] mh, mch, mt;

  // Monitor: compares DUT outputs mid-cycle against queued expectations.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.m[0]) begin
        n_vec++;
        if (free_count !== e.fc) begin
          n_miss++;
          $display("FAIL %s: free_count got %0d expected %0d", nm, free_count, e.fc);
        end
      end
      if (e.m[1]) begin
        n_vec++;
        if (alloc_ok !== e.ok) begin
          n_miss++;
          $display("FAIL %s: alloc_ok got %0b expected %0b", nm, alloc_ok, e.ok);
        end
      end
      if (e.m[2]) begin
        n_vec++;
        if (alloc_preg_0 !== e.p0) begin
          n_miss++;
          $display("FAIL %s: alloc_preg_0 got %0d expected %0d", nm, alloc_preg_0, e.p0);
        end
      end
      if (e.m[3]) begin
        n_vec++;
        if (alloc_preg_1 !== e.p1) begin
          n_miss++;
          $display("FAIL %s: alloc_preg_1 got %0d expected %0d", nm, alloc_preg_1, e.p1);
        end
      end
    end
  end

  function automatic logic [1:0] pc2(input logic [1:0] a);
    return {1'b0, a[0]} + {1'b0, a[1]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mfl[i] = (i < 30) ? 6'(34 + i) : 6'd0;
    mh  = 6'd0;
    mch = 6'd0;
    mt  = 6'd30;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [5:0] fc, ch_n;
    if (!rst_n) begin
      model_reset();
    end else begin
      fc   = mt - mh;
      ch_n = mch + 6'(pc2(commit_alloc));
      if (flush) mh = ch_n;
      else if (fc >= 6'(pc2(alloc_req))) mh = mh + 6'(pc2(alloc_req));
      if (commit_free_valid[0]) begin
        mfl[mt[4:0]] = commit_free_preg_0;
        mt = mt + 6'd1;
      end
      if (commit_free_valid[1]) begin
        mfl[mt[4:0]] = commit_free_preg_1;
        mt = mt + 6'd1;
      end
      mch = ch_n;
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then advance.
  task automatic cyc(input logic [1:0] ar, input logic [1:0] ca, input logic [1:0] fv,
                     input logic [5:0] f0, input logic [5:0] f1, input logic fl_i,
                     input logic [3:0] m, input logic [5:0] efc, input logic eok,
                     input logic [5:0] ep0, input logic [5:0] ep1, input string name);
    exp_t x;
    alloc_req          = ar;
    commit_alloc       = ca;
    commit_free_valid  = fv;
    commit_free_preg_0 = f0;
    commit_free_preg_1 = f1;
    flush              = fl_i;
    if (m != 4'd0) begin
      x.fc = efc; x.ok = eok; x.p0 = ep0; x.p1 = ep1; x.m = m;
      exp_q.push_back(x);
      name_q.push_back(name);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] pick_bits(input int cnt);
    if (cnt == 0) return 2'b00;
    if (cnt == 2) return 2'b11;
    return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
  endfunction

  // Random cycle respecting the legality rules; expectation comes from the model.
  task automatic rcyc();
    logic [1:0] ar, ca, fv;
    logic [5:0] outst, occ, fc, p0, p1;
    logic [4:0] i1;
    logic       fl_i;
    int         mx_c, mx_f;
    ar    = 2'($urandom_range(0, 3));
    fl_i  = ($urandom_range(0, 9) == 0);
    outst = mh - mch;
    mx_c  = (outst > 6'd2) ? 2 : int'(outst);
    ca    = pick_bits($urandom_range(0, mx_c));
    occ   = mt - mch;
    mx_f  = (occ >= 6'd30) ? int'(6'd32 - occ) : 2;
    fv    = pick_bits($urandom_range(0, mx_f));
    fc    = mt - mh;
    i1    = 5'(mh[4:0] + 5'd1);
    p0    = mfl[mh[4:0]];
    p1    = ar[0] ? mfl[i1] : mfl[mh[4:0]];
    cyc(ar, ca, fv, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), fl_i,
        4'hF, fc, (fc >= 6'(pc2(ar))), p0, p1, "random");
  endtask

  initial begin
    rst_n = 1'b0;
    alloc_req = '0; commit_alloc = '0; commit_free_valid = '0;
    commit_free_preg_0 = '0; commit_free_preg_1 = '0; flush = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cyc(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 4'hF, 6'd30, 1'b1, 6'd34, 6'd35, "reset");
    rst_n = 1'b1;

    for (int k = 0; k < 15; k++)
      cyc(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 4'hF, 6'(30 - 2 * k), 1'b1,
          6'(34 + 2 * k), 6'(35 + 2 * k), "drain");
    cyc(2'b01, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 4'b0011, 6'd0, 1'b0, 6'd0, 6'd0, "drain_empty");
    cyc(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 4'b0001, 6'd0, 1'b1, 6'd0, 6'd0, "head_held");
    cyc(2'b00, 2'b00, 2'b11, 6'd5, 6'd9, 1'b0, 4'b0001, 6'd0, 1'b1, 6'd0, 6'd0, "release_cycle");
    cyc(2'b01, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 4'hF, 6'd2, 1'b1, 6'd5, 6'd9, "release_grant0");
    cyc(2'b10, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 4'b1011, 6'd1, 1'b1, 6'd0, 6'd9, "release_grant1");
    cyc(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 4'b0001, 6'd0, 1'b1, 6'd0, 6'd0, "release_drained");

    // Asynchronous reset mid-cycle with an allocation pending.
    rst_n = 1'b0;
    cyc(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 4'hF, 6'd30, 1'b1, 6'd34, 6'd35, "async_reset");
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++)
      cyc(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 4'hF, 6'(30 - 2 * k), 1'b1,
          6'(34 + 2 * k), 6'(35 + 2 * k), "alloc6");
    cyc(2'b00, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 4'b0001, 6'd24, 1'b1, 6'd0, 6'd0, "commit2");
    cyc(2'b00, 2'b01, 2'b00, 6'd0, 6'd0, 1'b1, 4'b0001, 6'd24, 1'b1, 6'd0, 6'd0, "flush_cycle");
    cyc(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 4'b0101, 6'd27, 1'b1, 6'd37, 6'd0, "flush_recover");

    cyc(2'b11, 2'b00, 2'b01, 6'd12, 6'd0, 1'b1, 4'b0011, 6'd27, 1'b1, 6'd0, 6'd0, "collision_cycle");
    for (int k = 0; k < 13; k++)
      cyc(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 4'hF, 6'(28 - 2 * k), 1'b1,
          6'(37 + 2 * k), 6'(38 + 2 * k), "post_collision");
    cyc(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 4'hF, 6'd2, 1'b1, 6'd63, 6'd12, "appended_12");
    cyc(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 4'b0001, 6'd0, 1'b1, 6'd0, 6'd0, "collision_drained");

    rst_n = 1'b0;
    cyc(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 4'b0001, 6'd30, 1'b1, 6'd0, 6'd0, "reset_random");
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) rcyc();

    alloc_req = '0; commit_alloc = '0; commit_free_valid = '0; flush = 1'b0;
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/prf_freelist.md
# prf_freelist

Physical-register free list for the rename stage, directly upstream of the physical register file. It hands out up to two free physical register numbers per cycle to renamed instructions and takes back up to two stale registers per cycle from commit. A committed-head pointer lets a pipeline flush return all speculatively allocated registers in one cycle. Every write port number (`wnum_*`) that reaches the register file was issued by this block.

## Interface
Parameters:
- `PRF_NUM`, 64: number of physical registers.
- `ARCH_NUM`, 34: architectural registers (32 GPR + hi + lo). Physical registers 0..ARCH_NUM-1 are the reset mapping and are never in the list at reset.
- `FL_DEPTH`, 32: queue storage entries. Power of two, at least PRF_NUM-ARCH_NUM.
- `PRF_NUM_WIDTH`, 6: clog2(PRF_NUM).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alloc_req` in 2: per rename slot, the slot needs a destination register.
- `alloc_ok` out 1: the free list can serve every bit set in `alloc_req`.
- `alloc_preg_0`, `alloc_preg_1` out PRF_NUM_WIDTH: registers granted to slot 0 and slot 1.
- `commit_alloc` in 2: per commit slot, the committing instruction had allocated a register.
- `commit_free_valid` in 2: per commit slot, a stale register is being released.
- `commit_free_preg_0`, `commit_free_preg_1` in PRF_NUM_WIDTH: the released registers.
- `flush` in 1: recover speculative allocations.
- `free_count` out clog2(FL_DEPTH)+1: number of registers in the list, counted against the speculative head.

## Operation
- Storage is a circular queue `fl[FL_DEPTH]`. Each pointer carries a wrap bit (clog2(FL_DEPTH)+1 bits):
  - `head`: speculative read pointer.
  - `chead`: committed read pointer.
  - `tail`: write pointer.
- Reset state:
  - `fl[i] = ARCH_NUM+i` for i < PRF_NUM-ARCH_NUM; all other entries are 0.
  - `head = chead = 0`, `tail = PRF_NUM-ARCH_NUM`.
  - Resulting outputs: `free_count = 30`, `alloc_preg_0 = 34`, `alloc_preg_1 = 35`, `alloc_ok = 1`.
- `free_count = tail - head`. `nreq = popcount(alloc_req)`. `alloc_ok = (free_count >= nreq)`.
- Grant mapping:
  - If `alloc_req[0]` is set, slot 0 gets `fl[head]`.
  - Slot 1 gets `fl[head+1]` if `alloc_req[0]` is set, otherwise `fl[head]`.
  - Unrequested outputs carry the same values but are don't-care.
- Allocation is all-or-nothing. The head advances by `nreq` only when `alloc_ok && !flush`. A partial grant never occurs.
- Release:
  - Slot 0 is pushed before slot 1.
  - `tail` advances by `popcount(commit_free_valid)`.
  - If only slot 1 is valid, it is written at `tail`.
- Commit: `chead` advances by `popcount(commit_alloc)`.
- Flush:
  - `head <= chead + popcount(commit_alloc)`, so a same-cycle commit is included.
  - Allocation in the flush cycle is ignored.
  - Same-cycle release and commit are applied normally.
- Simultaneous alloc and release are independent.
  - `alloc_ok` uses the pre-release count; there is no bypass of registers released in the same cycle.
  - Next-cycle `free_count = free_count - granted + released`.
- Wrap-around: indices use the low clog2(FL_DEPTH) pointer bits; wrap bits disambiguate full from empty.
- Illegal conditions (simulation assertions; RTL behaviour undefined):
  - A release that would make `tail - chead > FL_DEPTH`.
  - `chead` passing `head`.
  - Any pointer movement during reset.

## Timing
- Grant is combinational: `alloc_preg_*` and `alloc_ok` are valid in the same cycle as `alloc_req`, derived from registered state only.
- All pointer and storage updates take effect at the next rising edge. A released register can be granted from the cycle after its release.
- Flush takes one cycle: the first post-flush allocation may occur in the following cycle.
- Asserting `rst_n` low at any time, including mid-flush or mid-alloc, immediately restores the reset state asynchronously.

## Test plan
- Reset:
  - Deassert `rst_n`.
  - Required: `free_count = 30`, `alloc_preg_0 = 34`, `alloc_preg_1 = 35`, `alloc_ok = 1`.
- Drain:
  - `alloc_req = 11` for 15 cycles.
  - Required: grants 34..63 in order; then `free_count = 0`.
  - Then `alloc_req = 01`: `alloc_ok = 0`, head unchanged.
- Release after drain:
  - When empty, release 5 (slot 0) and 9 (slot 1) in one cycle.
  - Required next cycle: `free_count = 2`, `alloc_preg_0 = 5`, `alloc_preg_1 = 9`.
  - Then `alloc_req = 10` grants 9 to slot 1.
- Flush recovery:
  - Allocate 6 registers (34..39), then `commit_alloc = 11`.
  - Next cycle, `flush` with `commit_alloc = 01`.
  - Required: `free_count = 27`, `alloc_preg_0 = 37`.
- Flush collision:
  - In one cycle assert `flush`, `alloc_req = 11`, and `commit_free_valid = 01` with preg 12.
  - Required: no grant; 12 appended at the tail; `free_count` rises by 1 relative to the committed count.
- Wrap-around and simultaneous events:
  - Run 200 cycles of random alloc/release/commit/flush against a reference queue model.
  - Required: pointers wrap past 32; grant order, `free_count`, and `alloc_ok` match the model every cycle.
